// File: rtl/feeder_pkg.sv
// Shared state encoding and default word width for the serial feeder.
package feeder_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/feeder_hold_reg.sv
// One-entry word buffer: load captures the word and raises full, clear drops full.
module feeder_hold_reg
   import feeder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             full
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process evaluation order.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         q    <= '0;
         full <= 1'b0;
      end else if (load) begin
         q    <= d;
         full <= 1'b1;
      end else if (clear) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_feeder.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first bits out on w,
// with a one-word holding buffer so consecutive words stream without an idle bit.
module serial_feeder
   import feeder_pkg::*;
#(
   parameter int   WIDTH      = DEFAULT_WIDTH,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             w,
   output logic             busy,
   output logic             last_bit
);

   localparam int            CW      = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

   state_t           state, state_next;
   logic [WIDTH-1:0] shreg, shreg_next, hold_q;
   logic [CW-1:0]    cnt, cnt_next;
   logic             hold_full, hold_load, hold_clear;
   logic             xfer, cnt_zero;

   // Ready comes only from registered state and Reset, never from din_valid.
   assign din_ready = Reset && !hold_full;
   assign xfer      = din_valid && din_ready;
   assign cnt_zero  = (cnt == '0);
   assign busy      = (state == S_SHIFT);
   assign w         = busy ? shreg[WIDTH-1] : IDLE_LEVEL;
   assign last_bit  = busy && cnt_zero;

   feeder_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .Clock (Clock),
      .Reset (Reset),
      .load  (hold_load),
      .clear (hold_clear),
      .d     (din),
      .q     (hold_q),
      .full  (hold_full)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= S_IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         shreg <= shreg_next;
         cnt   <= cnt_next;
      end
   end

   // NOTE: every output of this block is defaulted first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      shreg_next = shreg;
      cnt_next   = cnt;
      hold_load  = 1'b0;
      hold_clear = 1'b0;
      case (state)
         S_IDLE: begin
            if (xfer) begin
               shreg_next = din;
               cnt_next   = CNT_MAX;
               state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (!cnt_zero) begin
               shreg_next = shreg << 1;
               cnt_next   = cnt - CW'(1);
               hold_load  = xfer;
            end else if (hold_full) begin
               // End of word with a buffered successor: continue without a gap.
               shreg_next = hold_q;
               cnt_next   = CNT_MAX;
               hold_clear = 1'b1;
            end else if (xfer) begin
               // Word offered exactly on the last bit bypasses the buffer.
               shreg_next = din;
               cnt_next   = CNT_MAX;
            end else begin
               shreg_next = shreg << 1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: doc/serial_feeder.md
# serial_feeder

Parallel-to-serial front end for the serial sequence-detector stage. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on `w`, which the detector samples every rising edge. A one-entry holding buffer allows back-to-back words to stream with no idle bit between them.

## Interface
- `WIDTH`, default 8, bits per word, minimum 2.
- `IDLE_LEVEL`, default 1'b0, level driven on `w` when no word is being shifted.

Ports:
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low; clears all state immediately.
- `din`  in  WIDTH  word to serialize; bit WIDTH-1 is sent first.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  block can accept `din` this cycle.
- `w`  out  1  serial bit to the detector's `w` input.
- `busy`  out  1  a word is being shifted (state SHIFT).
- `last_bit`  out  1  `w` currently carries bit 0 of the word.

## Operation
- Transfer occurs on a rising edge where `din_valid && din_ready` are both 1.
- `din_ready = Reset && !hold_full`. It depends only on registered state and `Reset`, with no path from `din_valid`.
- State machine has two states:
  - IDLE: on transfer, `shreg <= din`, `cnt <= WIDTH-1`, go to SHIFT.
  - SHIFT: each edge, `shreg <= shreg << 1` and `cnt <= cnt-1` while `cnt != 0`.
  - A transfer in SHIFT writes the holding register and sets `hold_full`.
- Outputs:
  - `w = busy ? shreg[WIDTH-1] : IDLE_LEVEL`.
  - `last_bit = busy && cnt == 0`.
- End of word: the edge where SHIFT has `cnt == 0`.
  - If `hold_full`: load `shreg` from hold, clear `hold_full`, `cnt <= WIDTH-1`, stay in SHIFT (gapless).
  - Else, if a transfer occurs on that edge: load `shreg` directly from `din` (bypass), stay in SHIFT (gapless).
  - Otherwise go to IDLE.
- `hold_full` set and clear never coincide: ready is 0 whenever hold is full.
- `din` is not captured without a transfer. Changing `din` while `din_valid` is low has no effect.
- `cnt` width is `$clog2(WIDTH)`. No wrap-around: `cnt` is never decremented below 0.

## Timing
- Reset low: IDLE, `shreg=0`, `cnt=0`, `hold_full=0`, `w=IDLE_LEVEL`, `busy=0`, `last_bit=0`, `din_ready=0`.
  - Takes effect asynchronously.
  - A word in flight and the held word are discarded.
- First rising edge after `Reset` deasserts: normal operation, `din_ready=1`.
- Latency: transfer at edge k → `w` = bit WIDTH-1 during cycle k+1, bit 0 during cycle k+WIDTH.
- Throughput: one word per WIDTH cycles sustained. Holding words back-to-back produces a continuous bitstream.
- Reset pulse in the middle of a word: `w` returns to `IDLE_LEVEL` while `Reset` is low. No partial word resumes.

## Structure
- Package `feeder_pkg`:
  - state encoding constants `S_IDLE=1'b0`, `S_SHIFT=1'b1`;
  - default `WIDTH`.
- One natural sub-module: `feeder_hold_reg`, a WIDTH-bit register with load enable, async active-low clear and full flag. It is reused for the holding buffer.
- Shift register, counter and FSM live in the top module.

## Test plan
- Reset with `din_valid=1` → `din_ready=0`, `w=0`, `busy=0`. After release, `din_ready=1` on the next cycle.
- Single word 8'hD0 → `w` = 1,1,0,1,0,0,0,0 over cycles k+1..k+8, `last_bit` only at k+8, then IDLE.
  - With the detector attached: its `z=1` exactly one cycle after the fourth bit is sampled.
- Back-to-back 8'hA5 then 8'h3C (second offered immediately) → 16 consecutive bits with no idle gap.
  - `din_ready=0` from the second transfer until the hold unloads.
- Bypass: offer the second word only on the `last_bit` cycle of the first → gapless continuation, `hold_full` stays 0.
- `Reset` pulsed low at bit 3 of 8'hFF → `w=0` immediately. After release, a new word 8'h81 shifts correctly from its MSB.
- `WIDTH=2`, words 2'b10, 2'b11 streamed → `w` = 1,0,1,1, `last_bit` on the 2nd and 4th bits.
